// File: rtl/cpu_defs.sv
// Shared encodings for the multicycle CPU: FSM states, instruction fields,
// ALU operation codes and datapath multiplexer selects.
package cpu_defs;

    typedef enum logic [3:0] {
        FETCH       = 4'd0,
        FETCH_WAIT  = 4'd1,
        DECODE      = 4'd2,
        MEM_ADDR    = 4'd3,
        MEM_RD      = 4'd4,
        MEM_RD_WAIT = 4'd5,
        MEM_WB      = 4'd6,
        MEM_WR      = 4'd7,
        R_EXEC      = 4'd8,
        R_WB        = 4'd9,
        ADDI_EXEC   = 4'd10,
        ADDI_WB     = 4'd11,
        BRANCH      = 4'd12,
        JUMP        = 4'd13,
        ILLEGAL     = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;

    localparam logic [2:0] ALU_NOP = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;

    localparam logic       MUXA_PC   = 1'b0;
    localparam logic       MUXA_REGA = 1'b1;

    localparam logic [1:0] MUXB_REGB    = 2'b00;
    localparam logic [1:0] MUXB_FOUR    = 2'b01;
    localparam logic [1:0] MUXB_IMM     = 2'b10;
    localparam logic [1:0] MUXB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_wr;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       mux_a;
        logic [1:0] mux_b;
        logic [2:0] alu;
        logic [1:0] pc_source;
        logic       opcode_err;
    } ctrl_t;

endpackage

// File: rtl/alu_decoder.sv
// Maps an R-type funct field to an ALU operation; unsupported functs
// return ALU_NOP and raise illegal.
module alu_decoder
    import cpu_defs::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       illegal
);

    always_comb begin
        alu_control = ALU_NOP;
        illegal     = 1'b0;
        case (funct)
            FN_ADD:  alu_control = ALU_ADD;
            FN_SUB:  alu_control = ALU_SUB;
            FN_AND:  alu_control = ALU_AND;
            FN_OR:   alu_control = ALU_OR;
            default: illegal     = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multicycle CPU control FSM (Moore). Outputs are registered alongside the
// state, so each output word is computed from the state being entered.
module control_unit
    import cpu_defs::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_wr,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       mux_a_control,
    output logic [1:0] mux_b_control,
    output logic [2:0] alu_control,
    output logic [1:0] pc_source,
    output logic       opcode_err
);

    state_t     state;
    state_t     state_nxt;
    ctrl_t      ctrl_q;
    logic [2:0] r_alu;
    logic       r_illegal;

    // The branch decision is made by the datapath from pc_write_cond & zero.
    logic unused_zero;
    assign unused_zero = zero;

    alu_decoder u_alu_decoder (
        .funct       (funct),
        .alu_control (r_alu),
        .illegal     (r_illegal)
    );

    function automatic ctrl_t ctrl_for(input state_t s, input logic [2:0] rtype_alu);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH_WAIT: begin
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
                c.mux_a     = MUXA_PC;
                c.mux_b     = MUXB_FOUR;
                c.alu       = ALU_ADD;
                c.pc_source = PCSRC_ALU;
            end
            DECODE: begin
                c.mux_a = MUXA_PC;
                c.mux_b = MUXB_IMM_SH2;
                c.alu   = ALU_ADD;
            end
            MEM_ADDR, ADDI_EXEC: begin
                c.mux_a = MUXA_REGA;
                c.mux_b = MUXB_IMM;
                c.alu   = ALU_ADD;
            end
            MEM_RD, MEM_RD_WAIT: c.iord = 1'b1;
            MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            MEM_WR: begin
                c.iord   = 1'b1;
                c.mem_wr = 1'b1;
            end
            R_EXEC: begin
                c.mux_a = MUXA_REGA;
                c.mux_b = MUXB_REGB;
                c.alu   = rtype_alu;
            end
            R_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            ADDI_WB: c.reg_write = 1'b1;
            BRANCH: begin
                c.mux_a         = MUXA_REGA;
                c.mux_b         = MUXB_REGB;
                c.alu           = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PCSRC_ALUOUT;
            end
            JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PCSRC_JUMP;
            end
            ILLEGAL: c.opcode_err = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_nxt = FETCH;
        case (state)
            FETCH:       state_nxt = FETCH_WAIT;
            FETCH_WAIT:  state_nxt = DECODE;
            DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_nxt = R_EXEC;
                    OP_LW, OP_SW: state_nxt = MEM_ADDR;
                    OP_ADDI:      state_nxt = ADDI_EXEC;
                    OP_BEQ:       state_nxt = BRANCH;
                    OP_J:         state_nxt = JUMP;
                    default:      state_nxt = ILLEGAL;
                endcase
            end
            MEM_ADDR:    state_nxt = (opcode == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD:      state_nxt = MEM_RD_WAIT;
            MEM_RD_WAIT: state_nxt = MEM_WB;
            R_EXEC:      state_nxt = r_illegal ? ILLEGAL : R_WB;
            ADDI_EXEC:   state_nxt = ADDI_WB;
            // Terminal states and the unused encoding all fall back to FETCH.
            default:     state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= FETCH;
            ctrl_q <= '0;
        end else begin
            state  <= state_nxt;
            ctrl_q <= ctrl_for(state_nxt, r_alu);
        end
    end

    assign pc_write      = ctrl_q.pc_write;
    assign pc_write_cond = ctrl_q.pc_write_cond;
    assign iord          = ctrl_q.iord;
    assign mem_wr        = ctrl_q.mem_wr;
    assign ir_write      = ctrl_q.ir_write;
    assign reg_write     = ctrl_q.reg_write;
    assign reg_dst       = ctrl_q.reg_dst;
    assign mem_to_reg    = ctrl_q.mem_to_reg;
    assign mux_a_control = ctrl_q.mux_a;
    assign mux_b_control = ctrl_q.mux_b;
    assign alu_control   = ctrl_q.alu;
    assign pc_source     = ctrl_q.pc_source;
    assign opcode_err    = ctrl_q.opcode_err;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: an instruction-level phase model supplies
// the expected control word every cycle, pinned by hand-computed literals.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       pc_write, pc_write_cond, iord, mem_wr, ir_write, reg_write;
    logic       reg_dst, mem_to_reg, mux_a_control, opcode_err;
    logic [1:0] mux_b_control, pc_source;
    logic [2:0] alu_control;

    control_unit dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .funct         (funct),
        .zero          (zero),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .iord          (iord),
        .mem_wr        (mem_wr),
        .ir_write      (ir_write),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .mux_a_control (mux_a_control),
        .mux_b_control (mux_b_control),
        .alu_control   (alu_control),
        .pc_source     (pc_source),
        .opcode_err    (opcode_err)
    );

    always #5 clk = ~clk;

    // {pc_write, pc_write_cond, iord, mem_wr, ir_write, reg_write, reg_dst,
    //  mem_to_reg, mux_a, mux_b[1:0], alu[2:0], pc_source[1:0], opcode_err}
    logic [16:0] dut_word;
    assign dut_word = {pc_write, pc_write_cond, iord, mem_wr, ir_write, reg_write,
                       reg_dst, mem_to_reg, mux_a_control, mux_b_control,
                       alu_control, pc_source, opcode_err};

    logic [16:0] exp_now;
    logic [16:0] lit_word;
    logic        lit_en;
    logic        probe;
    string       tag;
    string       plan[$];
    int          n_vec = 0;
    int          n_err = 0;

    function automatic logic [16:0] mk(input logic pw, pwc, io, mw, irw, rw, rd, m2r, ma,
                                       input logic [1:0] mb, input logic [2:0] alu,
                                       input logic [1:0] ps, input logic err);
        return {pw, pwc, io, mw, irw, rw, rd, m2r, ma, mb, alu, ps, err};
    endfunction

    function automatic logic [2:0] r_alu_of(input logic [5:0] fn);
        if (fn == 6'h20) return 3'b001;
        if (fn == 6'h22) return 3'b010;
        if (fn == 6'h24) return 3'b011;
        if (fn == 6'h25) return 3'b100;
        return 3'b000;
    endfunction

    // Control word the datapath needs during each phase of an instruction.
    function automatic logic [16:0] word_of(input string ph, input logic [5:0] fn);
        case (ph)
            "FW":  return mk(1,0,0,0,1,0,0,0,0, 2'b01, 3'b001, 2'b00, 0);
            "D":   return mk(0,0,0,0,0,0,0,0,0, 2'b11, 3'b001, 2'b00, 0);
            "MA":  return mk(0,0,0,0,0,0,0,0,1, 2'b10, 3'b001, 2'b00, 0);
            "MR":  return mk(0,0,1,0,0,0,0,0,0, 2'b00, 3'b000, 2'b00, 0);
            "MWB": return mk(0,0,0,0,0,1,0,1,0, 2'b00, 3'b000, 2'b00, 0);
            "MW":  return mk(0,0,1,1,0,0,0,0,0, 2'b00, 3'b000, 2'b00, 0);
            "RX":  return mk(0,0,0,0,0,0,0,0,1, 2'b00, r_alu_of(fn), 2'b00, 0);
            "RW":  return mk(0,0,0,0,0,1,1,0,0, 2'b00, 3'b000, 2'b00, 0);
            "AX":  return mk(0,0,0,0,0,0,0,0,1, 2'b10, 3'b001, 2'b00, 0);
            "AW":  return mk(0,0,0,0,0,1,0,0,0, 2'b00, 3'b000, 2'b00, 0);
            "BR":  return mk(0,1,0,0,0,0,0,0,1, 2'b00, 3'b010, 2'b01, 0);
            "JP":  return mk(1,0,0,0,0,0,0,0,0, 2'b00, 3'b000, 2'b10, 0);
            "IL":  return mk(0,0,0,0,0,0,0,0,0, 2'b00, 3'b000, 2'b00, 1);
            default: return 17'd0;
        endcase
    endfunction

    task automatic build(input logic [5:0] op, input logic [5:0] fn);
        plan.delete();
        plan.push_back("F");
        plan.push_back("FW");
        plan.push_back("D");
        case (op)
            6'h00: begin
                plan.push_back("RX");
                plan.push_back(r_alu_of(fn) == 3'b000 ? "IL" : "RW");
            end
            6'h23: begin
                plan.push_back("MA"); plan.push_back("MR");
                plan.push_back("MR"); plan.push_back("MWB");
            end
            6'h2B: begin plan.push_back("MA"); plan.push_back("MW"); end
            6'h08: begin plan.push_back("AX"); plan.push_back("AW"); end
            6'h04: plan.push_back("BR");
            6'h02: plan.push_back("JP");
            default: plan.push_back("IL");
        endcase
    endtask

    always @(negedge clk or posedge probe) begin
        n_vec <= n_vec + (lit_en ? 2 : 1);
        n_err <= n_err + int'(dut_word !== exp_now) + int'(lit_en && (dut_word !== lit_word));
        if (dut_word !== exp_now)
            $display("FAIL %s model: got %b required %b", tag, dut_word, exp_now);
        if (lit_en && (dut_word !== lit_word))
            $display("FAIL %s literal: got %b required %b", tag, dut_word, lit_word);
    end

    // Entered one step after a rising edge with the DUT sitting in FETCH.
    task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input string name, input int lidx, input logic [16:0] lword);
        opcode = op;
        funct  = fn;
        zero   = z;
        build(op, fn);
        for (int i = 0; i < plan.size(); i++) begin
            tag      = $sformatf("%s c%0d", name, i + 1);
            exp_now  = word_of(plan[i], fn);
            lit_en   = (i == lidx);
            lit_word = lword;
            @(negedge clk);
            @(posedge clk);
            #1;
        end
        lit_en = 1'b0;
    endtask

    initial begin
        reset = 1'b0; opcode = '0; funct = '0; zero = 1'b0; probe = 1'b0;
        exp_now = '0; lit_en = 1'b0; lit_word = '0; tag = "reset";
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;

        run(6'h00, 6'h20, 0, "add",    4, 17'b0_0_0_0_0_1_1_0_0_00_000_00_0);
        run(6'h23, 6'h00, 0, "lw",     6, 17'b0_0_0_0_0_1_0_1_0_00_000_00_0);
        run(6'h2B, 6'h00, 0, "sw",     4, 17'b0_0_1_1_0_0_0_0_0_00_000_00_0);
        run(6'h04, 6'h00, 1, "beq_z1", 3, 17'b0_1_0_0_0_0_0_0_1_00_010_01_0);
        run(6'h04, 6'h00, 0, "beq_z0", 3, 17'b0_1_0_0_0_0_0_0_1_00_010_01_0);
        run(6'h08, 6'h00, 0, "addi",   2, 17'b0_0_0_0_0_0_0_0_0_11_001_00_0);
        run(6'h02, 6'h00, 0, "j",      1, 17'b1_0_0_0_1_0_0_0_0_01_001_00_0);
        run(6'h02, 6'h00, 0, "j_tgt",  3, 17'b1_0_0_0_0_0_0_0_0_00_000_10_0);
        run(6'h3F, 6'h00, 0, "op3f",   3, 17'b0_0_0_0_0_0_0_0_0_00_000_00_1);
        run(6'h00, 6'h27, 0, "fn27",   4, 17'b0_0_0_0_0_0_0_0_0_00_000_00_1);
        run(6'h00, 6'h22, 0, "sub",    3, 17'b0_0_0_0_0_0_0_0_1_00_010_00_0);
        run(6'h00, 6'h24, 0, "and",    3, 17'b0_0_0_0_0_0_0_0_1_00_011_00_0);
        run(6'h00, 6'h25, 0, "or",     3, 17'b0_0_0_0_0_0_0_0_1_00_100_00_0);

        // sw interrupted by reset while MEM_WR is driving the write strobe
        opcode = 6'h2B; funct = 6'h00; zero = 1'b0;
        build(6'h2B, 6'h00);
        for (int i = 0; i < 5; i++) begin
            tag     = $sformatf("sw_rst c%0d", i + 1);
            exp_now = word_of(plan[i], 6'h00);
            @(negedge clk);
            if (i < 4) begin
                @(posedge clk);
                #1;
            end
        end
        #1 reset = 1'b0;
        #1;
        tag      = "rst_mid";
        exp_now  = '0;
        lit_en   = 1'b1;
        lit_word = '0;
        probe    = 1'b1;
        #1 probe = 1'b0;
        lit_en   = 1'b0;
        tag      = "rst_hold";
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;

        run(6'h00, 6'h20, 0, "add_after_rst", 1, 17'b1_0_0_0_1_0_0_0_0_01_001_00_0);

        tag     = "final_fetch";
        exp_now = '0;
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state changes on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port opcode, input, 6 bits: instruction bits [31:26] from the instruction register.
REQ-004 SHALL have port funct, input, 6 bits: instruction bits [5:0].
REQ-005 SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-006 SHALL have port pc_write, output, 1 bit: unconditional PC load.
REQ-007 SHALL have port pc_write_cond, output, 1 bit: PC load qualified by zero.
REQ-008 SHALL have port iord, output, 1 bit: memory address select (0 = PC, 1 = ALUOut).
REQ-009 SHALL have port mem_wr, output, 1 bit: memory write strobe.
REQ-010 SHALL have port ir_write, output, 1 bit: instruction register load.
REQ-011 SHALL have port reg_write, output, 1 bit: register file write.
REQ-012 SHALL have port reg_dst, output, 1 bit: write register select (0 = rt, 1 = rd).
REQ-013 SHALL have port mem_to_reg, output, 1 bit: write data select (0 = ALUOut, 1 = MDR).
REQ-014 SHALL have port mux_a_control, output, 1 bit: ALU A select (0 = PC, 1 = regA).
REQ-015 SHALL have port mux_b_control, output, 2 bits: ALU B select (00 = regB, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2).
REQ-016 SHALL have port alu_control, output, 3 bits: 001 add, 010 sub, 011 and, 100 or.
REQ-017 SHALL have port pc_source, output, 2 bits: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-018 SHALL have port opcode_err, output, 1 bit: one-cycle pulse on an unsupported instruction.

Function
REQ-019 SHALL be a Moore FSM; every output is a registered function of the current state only.
REQ-020 SHALL use states FETCH, FETCH_WAIT, DECODE, MEM_ADDR, MEM_RD, MEM_RD_WAIT, MEM_WB, MEM_WR, R_EXEC, R_WB, ADDI_EXEC, ADDI_WB, BRANCH, JUMP and ILLEGAL.
REQ-021 SHALL use the transitions FETCH -> FETCH_WAIT -> DECODE, because memory has one cycle of read latency.
REQ-022 SHALL, in FETCH_WAIT, assert ir_write, pc_write, mux_a=0, mux_b=01, alu=add and pc_source=00.
REQ-023 SHALL, in DECODE, assert mux_a=0, mux_b=11 and alu=add, so that the branch target is precomputed into ALUOut.
REQ-024 SHALL leave DECODE by opcode: 0x00 -> R_EXEC; 0x23 or 0x2B -> MEM_ADDR; 0x08 -> ADDI_EXEC; 0x04 -> BRANCH; 0x02 -> JUMP; any other opcode -> ILLEGAL.
REQ-025 SHALL, in R_EXEC, drive mux_a=1 and mux_b=00, with alu taken from funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or.
REQ-026 SHALL treat an R-type with any other funct as illegal: R_EXEC -> ILLEGAL, with no reg_write.
REQ-027 SHALL, in R_WB, assert reg_write, reg_dst=1 and mem_to_reg=0, then return to FETCH.
REQ-028 SHALL, in MEM_ADDR, drive mux_a=1, mux_b=10 and alu=add, then go to MEM_RD on lw or MEM_WR on sw.
REQ-029 SHALL follow the lw path MEM_RD (iord=1) -> MEM_RD_WAIT (iord=1) -> MEM_WB (reg_write, reg_dst=0, mem_to_reg=1) -> FETCH.
REQ-030 SHALL, in MEM_WR, assert iord=1 and mem_wr for exactly one cycle, then go to FETCH.
REQ-031 SHALL, in ADDI_EXEC, drive mux_a=1, mux_b=10 and alu=add; ADDI_WB asserts reg_write, reg_dst=0 and mem_to_reg=0, then FETCH.
REQ-032 SHALL, in BRANCH, drive mux_a=1, mux_b=00, alu=sub, pc_write_cond=1 and pc_source=01, then FETCH.
REQ-033 SHALL, in JUMP, assert pc_write and pc_source=10, then FETCH.
REQ-034 SHALL, in ILLEGAL, pulse opcode_err for one cycle with all write strobes low, then go to FETCH.
REQ-035 SHALL hold every write strobe (pc_write, pc_write_cond, mem_wr, ir_write, reg_write) at 0 in every state not listed above as asserting it.
REQ-036 SHALL drive zeros on unlisted mux and ALU selects.
REQ-037 SHALL decode states with full coverage; an unreachable encoding goes to FETCH on the next edge.

Reset
REQ-038 SHALL, when reset is low, immediately force state FETCH and all outputs 0, independent of clk, including when reset arrives mid-instruction.
REQ-039 SHALL, on reset deassertion, start FETCH at the next rising clk with no spurious write strobe.

Structure
REQ-040 SHALL define the state encoding, opcode/funct constants, alu_control codes and mux select codes in a shared package, cpu_defs, also used by the multiplexers and the ALU.
REQ-041 SHALL contain a single sub-module, alu_decoder (funct -> alu_control, plus an illegal flag), instantiated in the R_EXEC path.

Verification
REQ-042 SHALL cover: add (opcode 0x00, funct 0x20) -> states FETCH, FETCH_WAIT, DECODE, R_EXEC, R_WB; reg_write=1, reg_dst=1 only in cycle 5.
REQ-043 SHALL cover: lw (0x23) -> 7 cycles; mem_to_reg=1 and reg_write=1 only in MEM_WB; iord=1 in MEM_RD and MEM_RD_WAIT.
REQ-044 SHALL cover: sw (0x2B) -> mem_wr high for exactly 1 cycle, in cycle 5; reg_write never asserted.
REQ-045 SHALL cover: beq (0x04) with zero=1 -> pc_write_cond=1 and pc_source=01 in cycle 4; with zero=0, the same strobes and control returns to FETCH.
REQ-046 SHALL cover: opcode 0x3F, or funct 0x27 -> opcode_err pulses 1 cycle, no write strobes, next state FETCH.
REQ-047 SHALL cover: reset driven low mid-cycle in MEM_WR -> mem_wr drops to 0 before the next edge, state is FETCH, all outputs 0.
